// File: rtl/btn_event_ctrl.sv
// Multi-button debounce front-end with round-robin event serialiser (valid/ready).
// Optional auto-repeat of the lowest held button: define BTN_AUTOREPEAT_EN.
module btn_event_ctrl #(
    parameter int NUM_BTN   = 4,
    parameter int TICK_DIV  = 50000,
    parameter int DEB_TICKS = 16,
    parameter int IDW       = 2
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic [NUM_BTN-1:0] btn_state,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IDW-1:0]     evt_id,
    output logic               evt_press,
    input  logic               ovr_clr,
    output logic               evt_overrun
);

    localparam int PCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DCW = $clog2(DEB_TICKS + 1);

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [NUM_BTN-1:0] r_btn_state;
    logic [NUM_BTN-1:0] r_pending;
    logic [NUM_BTN-1:0] r_pdir;
    logic [PCW-1:0]     r_presc;
    logic               r_evt_valid;
    logic               r_evt_press;
    logic               r_evt_overrun;
    logic [IDW-1:0]     r_evt_id;
    logic [IDW-1:0]     r_last_grant;

    logic               w_tick;
    logic [NUM_BTN-1:0] w_edge;
    logic [NUM_BTN-1:0] w_set;
    logic [NUM_BTN-1:0] w_set_dir;
    logic [NUM_BTN-1:0] w_grant_hit;
    logic [NUM_BTN-1:0] w_ovr_set;
    logic [NUM_BTN-1:0] w_rep_fire;
    logic [NUM_BTN-1:0] w_state_next;
    logic [NUM_BTN-1:0] w_pending_next;
    logic [NUM_BTN-1:0] w_pdir_next;
    logic [IDW-1:0]     w_grant_idx;
    logic               w_grant_dir;
    logic               w_found;
    logic               w_free;
    logic               w_load;

    // Buttons are active-low; invert before the first synchroniser stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~btn_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_presc == PCW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic [DCW-1:0] r_cnt;
            logic           w_differ;

            assign w_differ = (r_sync2[gi] != r_btn_state[gi]);

            always_ff @(posedge clk) begin
                if (rst || !w_differ) begin
                    r_cnt <= '0;
                end else if (w_tick) begin
                    if (r_cnt == DCW'(DEB_TICKS - 1)) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_edge[gi]       = w_differ && w_tick && (r_cnt == DCW'(DEB_TICKS - 1));
            assign w_state_next[gi] = w_edge[gi] ? ~r_btn_state[gi] : r_btn_state[gi];
            assign w_set[gi]        = w_edge[gi] | w_rep_fire[gi];
            assign w_set_dir[gi]    = w_edge[gi] ? ~r_btn_state[gi] : 1'b1;
            assign w_grant_hit[gi]  = w_load && (w_grant_idx == IDW'(gi));

            // A new edge wins over a same-cycle grant: the grant carries the old direction.
            assign w_pending_next[gi] = w_set[gi] | (r_pending[gi] & ~w_grant_hit[gi]);
            assign w_pdir_next[gi]    = w_set[gi] ? w_set_dir[gi] : r_pdir[gi];
            assign w_ovr_set[gi]      = w_set[gi] & r_pending[gi] & ~w_grant_hit[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_state <= '0;
            r_pending   <= '0;
            r_pdir      <= '0;
        end else begin
            r_btn_state <= w_state_next;
            r_pending   <= w_pending_next;
            r_pdir      <= w_pdir_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt_overrun <= 1'b0;
        end else if (|w_ovr_set) begin
            r_evt_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_evt_overrun <= 1'b0;
        end
    end

    // Round-robin: lowest pending index above last_grant, else lowest at or below it.
    always_comb begin
        w_grant_idx = '0;
        w_grant_dir = 1'b0;
        w_found     = 1'b0;
        for (int j = 0; j < NUM_BTN; j++) begin
            if (!w_found && r_pending[j] && (IDW'(j) > r_last_grant)) begin
                w_found     = 1'b1;
                w_grant_idx = IDW'(j);
                w_grant_dir = r_pdir[j];
            end
        end
        for (int j = 0; j < NUM_BTN; j++) begin
            if (!w_found && r_pending[j] && (IDW'(j) <= r_last_grant)) begin
                w_found     = 1'b1;
                w_grant_idx = IDW'(j);
                w_grant_dir = r_pdir[j];
            end
        end
    end

    assign w_free = ~r_evt_valid | evt_ready;
    assign w_load = w_free & w_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt_valid  <= 1'b0;
            r_evt_id     <= '0;
            r_evt_press  <= 1'b0;
            r_last_grant <= IDW'(NUM_BTN - 1);
        end else if (w_free) begin
            if (w_found) begin
                r_evt_valid  <= 1'b1;
                r_evt_id     <= w_grant_idx;
                r_evt_press  <= w_grant_dir;
                r_last_grant <= w_grant_idx;
            end else begin
                r_evt_valid  <= 1'b0;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW  = $clog2(RMAX + 1);

    logic [IDW-1:0] r_rep_idx;
    logic [RCW-1:0] r_rep_cnt;
    logic           r_rep_trk;
    logic           r_rep_phase;
    logic [IDW-1:0] w_low_idx;
    logic           w_any_held;
    logic           w_rep_restart;
    logic           w_rep_hit;

    always_comb begin
        w_low_idx  = '0;
        w_any_held = 1'b0;
        for (int j = NUM_BTN - 1; j >= 0; j--) begin
            if (r_btn_state[j]) begin
                w_low_idx  = IDW'(j);
                w_any_held = 1'b1;
            end
        end
    end

    assign w_rep_restart = !w_any_held || !r_rep_trk || (w_low_idx != r_rep_idx);
    assign w_rep_hit = !w_rep_restart && w_tick &&
                       (r_rep_cnt == (r_rep_phase ? RCW'(REPEAT_RATE - 1) : RCW'(REPEAT_DELAY - 1)));

    // First fire after REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_trk   <= 1'b0;
            r_rep_idx   <= '0;
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_rep_restart) begin
            r_rep_trk   <= w_any_held;
            r_rep_idx   <= w_low_idx;
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
        end else if (w_tick) begin
            if (w_rep_hit) begin
                r_rep_cnt   <= '0;
                r_rep_phase <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_rep
            assign w_rep_fire[gi] = w_rep_hit && (r_rep_idx == IDW'(gi));
        end
    endgenerate
`else
    assign w_rep_fire = '0;
`endif

    assign btn_state   = r_btn_state;
    assign evt_valid   = r_evt_valid;
    assign evt_id      = r_evt_id;
    assign evt_press   = r_evt_press;
    assign evt_overrun = r_evt_overrun;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: NUM_BTN=4, TICK_DIV=4, DEB_TICKS=3.
module tb_btn_event_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_n;
    logic [3:0] btn_state;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_press;
    logic       ovr_clr;
    logic       evt_overrun;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int id;
        int press;
        int cyc;
    } ev_t;
    ev_t evq[$];

    btn_event_ctrl #(
        .NUM_BTN(4),
        .TICK_DIV(4),
        .DEB_TICKS(3),
        .IDW(2)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY(4),
        .REPEAT_RATE(2)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_n(btn_n),
        .btn_state(btn_state),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id(evt_id),
        .evt_press(evt_press),
        .ovr_clr(ovr_clr),
        .evt_overrun(evt_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            ev_t e;
            e.id    = int'(evt_id);
            e.press = int'(evt_press);
            e.cyc   = cyc;
            evq.push_back(e);
            $display("event id=%0d press=%0d cyc=%0d", e.id, e.press, e.cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; btn_n = 4'hF; evt_ready = 1'b1; ovr_clr = 1'b0;
        cycles(2);
        @(negedge clk);
        checks++; if (btn_state !== 4'h0) begin errors++; $display("FAIL reset_state: got %h expected 0", btn_state); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
        checks++; if (evt_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", evt_id); end
        checks++; if (evt_press !== 1'b0) begin errors++; $display("FAIL reset_press: got %b expected 0", evt_press); end
        checks++; if (evt_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", evt_overrun); end
        @(posedge clk); #1;
        rst = 1'b0;
        evq.delete();
        btn_n = 4'h0;
        cycles(22);
        checks++; if (evq.size() != 4) begin errors++; $display("FAIL first_grant_count: got %0d expected 4", evq.size()); end
        if (evq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (evq[i].id != i || evq[i].press != 1) begin
                    errors++; $display("FAIL first_grant_order[%0d]: got id=%0d press=%0d expected id=%0d press=1", i, evq[i].id, evq[i].press, i);
                end
                if (i > 0) begin
                    checks++;
                    if (evq[i].cyc - evq[i-1].cyc != 1) begin
                        errors++; $display("FAIL first_grant_b2b[%0d]: got gap %0d expected 1", i, evq[i].cyc - evq[i-1].cyc);
                    end
                end
            end
        end
        evq.delete();
        btn_n = 4'hF;
        cycles(30);
        checks++; if (evq.size() != 4) begin errors++; $display("FAIL release_all_count: got %0d expected 4", evq.size()); end
        if (evq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (evq[i].id != i || evq[i].press != 0) begin
                    errors++; $display("FAIL release_all_order[%0d]: got id=%0d press=%0d expected id=%0d press=0", i, evq[i].id, evq[i].press, i);
                end
            end
        end
        evq.delete();
    endtask

    task automatic test_clean_press;
        int lat;
        lat = 0;
        evq.delete();
        btn_n[2] = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (btn_state[2]) begin
                lat = n - 1;
                break;
            end
        end
        checks++; if (lat < 11 || lat > 15) begin errors++; $display("FAIL press_latency: got %0d cycles expected 11..15", lat); end
        cycles(40);
        checks++; if (evq.size() != 1) begin errors++; $display("FAIL press_count: got %0d expected 1", evq.size()); end
        if (evq.size() == 1) begin
            checks++;
            if (evq[0].id != 2 || evq[0].press != 1) begin errors++; $display("FAIL press_event: got id=%0d press=%0d expected id=2 press=1", evq[0].id, evq[0].press); end
        end
        evq.delete();
        btn_n[2] = 1'b1;
        cycles(40);
        checks++; if (evq.size() != 1) begin errors++; $display("FAIL release_count: got %0d expected 1", evq.size()); end
        if (evq.size() == 1) begin
            checks++;
            if (evq[0].id != 2 || evq[0].press != 0) begin errors++; $display("FAIL release_event: got id=%0d press=%0d expected id=2 press=0", evq[0].id, evq[0].press); end
        end
        checks++; if (btn_state !== 4'h0) begin errors++; $display("FAIL release_state: got %h expected 0", btn_state); end
        evq.delete();
    endtask

    task automatic test_glitch;
        int seen;
        seen = 0;
        evq.delete();
        btn_n[1] = 1'b0;
        cycles(3);
        btn_n[1] = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (btn_state[1] || evt_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL glitch_state: got %0d active cycles expected 0", seen); end
        checks++; if (evq.size() != 0) begin errors++; $display("FAIL glitch_events: got %0d expected 0", evq.size()); end
        cycles(1);
    endtask

    task automatic test_back_pressure;
        int bad;
        bad = 0;
        evt_ready = 1'b0;
        evq.delete();
        btn_n[0] = 1'b0;
        cycles(20);
        btn_n[3] = 1'b0;
        cycles(20);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_press !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles (valid=%b id=%0d) expected 0", bad, evt_valid, evt_id); end
        @(posedge clk); #1;
        evt_ready = 1'b1;
        cycles(4);
        checks++; if (evq.size() != 2) begin errors++; $display("FAIL bp_count: got %0d expected 2", evq.size()); end
        if (evq.size() == 2) begin
            checks++;
            if (evq[0].id != 0 || evq[0].press != 1) begin errors++; $display("FAIL bp_first: got id=%0d press=%0d expected id=0 press=1", evq[0].id, evq[0].press); end
            checks++;
            if (evq[1].id != 3 || evq[1].press != 1) begin errors++; $display("FAIL bp_second: got id=%0d press=%0d expected id=3 press=1", evq[1].id, evq[1].press); end
            checks++;
            if (evq[1].cyc - evq[0].cyc != 1) begin errors++; $display("FAIL bp_b2b: got gap %0d expected 1", evq[1].cyc - evq[0].cyc); end
        end
        evq.delete();
        btn_n = 4'hF;
        cycles(40);
        checks++; if (evq.size() != 2) begin errors++; $display("FAIL bp_release_count: got %0d expected 2", evq.size()); end
        evq.delete();
    endtask

    task automatic test_overrun;
        evt_ready = 1'b0;
        evq.delete();
        btn_n[2] = 1'b0;
        cycles(20);
        btn_n[1] = 1'b0;
        cycles(20);
        btn_n[1] = 1'b1;
        cycles(20);
        @(negedge clk);
        checks++; if (evt_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", evt_overrun); end
        checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin errors++; $display("FAIL ovr_held: got valid=%b id=%0d expected valid=1 id=2", evt_valid, evt_id); end
        @(posedge clk); #1;
        evt_ready = 1'b1;
        cycles(4);
        checks++; if (evq.size() != 2) begin errors++; $display("FAIL ovr_count: got %0d expected 2", evq.size()); end
        if (evq.size() == 2) begin
            checks++;
            if (evq[0].id != 2 || evq[0].press != 1) begin errors++; $display("FAIL ovr_first: got id=%0d press=%0d expected id=2 press=1", evq[0].id, evq[0].press); end
            checks++;
            if (evq[1].id != 1 || evq[1].press != 0) begin errors++; $display("FAIL ovr_delivered: got id=%0d press=%0d expected id=1 press=0", evq[1].id, evq[1].press); end
        end
        checks++; if (evt_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", evt_overrun); end
        ovr_clr = 1'b1;
        cycles(1);
        ovr_clr = 1'b0;
        @(negedge clk);
        checks++; if (evt_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", evt_overrun); end
        @(posedge clk); #1;
        btn_n[2] = 1'b1;
        cycles(40);
        evq.delete();
    endtask

    task automatic test_reset_midop;
        evt_ready = 1'b0;
        btn_n[0] = 1'b0;
        cycles(20);
        btn_n[3] = 1'b0;
        cycles(20);
        @(negedge clk);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got valid=%b expected 1", evt_valid); end
        @(posedge clk); #1;
        btn_n = 4'hF;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", evt_valid); end
        checks++; if (btn_state !== 4'h0) begin errors++; $display("FAIL midrst_state: got %h expected 0", btn_state); end
        @(posedge clk); #1;
        evq.delete();
        evt_ready = 1'b1;
        cycles(40);
        checks++; if (evq.size() != 0) begin errors++; $display("FAIL midrst_discard: got %0d events expected 0", evq.size()); end
        evq.delete();
    endtask

`ifdef BTN_AUTOREPEAT_EN
    task automatic test_autorepeat;
        int npress;
        npress = 0;
        evq.delete();
        btn_n[0] = 1'b0;
        cycles(160);
        btn_n[0] = 1'b1;
        cycles(40);
        checks++; if (evq.size() < 10) begin errors++; $display("FAIL rep_count: got %0d expected at least 10", evq.size()); end
        if (evq.size() >= 10) begin
            for (int i = 0; i < evq.size() - 1; i++) begin
                checks++;
                if (evq[i].id != 0 || evq[i].press != 1) begin errors++; $display("FAIL rep_press[%0d]: got id=%0d press=%0d expected id=0 press=1", i, evq[i].id, evq[i].press); end
                if (i > 0) begin
                    checks++;
                    if (evq[i].cyc - evq[i-1].cyc != ((i == 1) ? 16 : 8)) begin
                        errors++; $display("FAIL rep_gap[%0d]: got %0d expected %0d", i, evq[i].cyc - evq[i-1].cyc, (i == 1) ? 16 : 8);
                    end
                end
            end
            checks++;
            if (evq[evq.size()-1].press != 0) begin errors++; $display("FAIL rep_release_last: got press=%0d expected 0", evq[evq.size()-1].press); end
        end
        evq.delete();
    endtask
`endif

    initial begin
        test_reset();
`ifdef BTN_AUTOREPEAT_EN
        test_autorepeat();
`else
        test_clean_press();
        test_glitch();
        test_back_pressure();
        test_overrun();
        test_reset_midop();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
